conv2d_window_generator: RTL and testbench
==========================================

# conv2d_window_generator

Streaming producer for the conv2d dot-product datapath. It accepts a raster-ordered image one pixel per handshake and buffers the last FILTER_SIZE-1 rows in line buffers. It emits every fully-populated FILTER_SIZE×FILTER_SIZE patch ("valid" convolution, no padding) over a valid/ready interface. Its patch output is row-major and connects directly to the accelerator's `image_patch` input.

## Interface
- `FILTER_SIZE`, 3: window edge length; must be ≥2 and ≤ `IMG_WIDTH`, `IMG_HEIGHT`.
- `DATA_WIDTH`, 8: pixel width.
- `IMG_WIDTH`, 8: pixels per row.
- `IMG_HEIGHT`, 8: rows per frame.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `pix_valid`  in  1  `pix_data` is valid.
- `pix_ready`  out  1  block can accept a pixel this cycle.
- `pix_data`  in  `DATA_WIDTH`  pixel in raster order (row 0 col 0 first).
- `window_valid`  out  1  `image_patch` holds a complete window.
- `window_ready`  in  1  downstream accepts the window this cycle.
- `image_patch`  out  [`DATA_WIDTH`-1:0] [`FILTER_SIZE`-1:0][`FILTER_SIZE`-1:0]  window; `[i][j]`: i=0 oldest/top row, j=0 leftmost column.
- `frame_done`  out  1  one-cycle pulse when the last window of a frame is accepted.

## Operation
- Pixel accepted when `pix_valid && pix_ready`. Window accepted when `window_valid && window_ready`.
- Counters `col` (0..`IMG_WIDTH`-1) and `row` (0..`IMG_HEIGHT`-1) advance only on pixel acceptance. `col` wraps to 0 and increments `row`. At (`IMG_HEIGHT`-1, `IMG_WIDTH`-1) both wrap to 0, and the next pixel starts a new frame.
- Line buffers: `FILTER_SIZE`-1 row memories, depth `IMG_WIDTH`, indexed by `col`.
  - On acceptance, the column read is {line[0][col] … line[FS-2][col], pix_data} (top to bottom).
  - The buffers shift: line[k][col] ← line[k+1][col], and line[FS-2][col] ← pix_data.
- Window register: on acceptance, columns shift left (`[i][j]` ← `[i][j+1]`), and column FS-1 is loaded with the read column.
- A window is produced by the accepted pixel when `row` ≥ FS-1 and `col` ≥ FS-1 (pre-increment values).
  - Windows per frame: (`IMG_WIDTH`-FS+1)·(`IMG_HEIGHT`-FS+1).
- FSM states:
  - FILL: `row` < FS-1; no windows produced. Exits to RUN when the first pixel of row FS-1 is accepted.
  - RUN: windows produced per the column rule. Returns to FILL when the frame wrap occurs.
- Stale data: windows at column wrap and line-buffer contents from the previous frame are never emitted, because the gating above excludes them.
- No arithmetic beyond the counters. The window is a pure data copy at full `DATA_WIDTH`.

## Timing
- Reset (`rst`=0 at a clock edge) forces:
  - `window_valid`=0, `frame_done`=0, `pix_ready`=1, `image_patch`=all 0.
  - `col`=`row`=0, FSM=FILL.
  - Line-buffer contents need not be cleared.
- Reset mid-frame discards the partial frame. The next accepted pixel is row 0 col 0.
- Latency: `window_valid` rises in the cycle after the completing pixel is accepted.
- `pix_ready` = !`window_valid` || `window_ready`. A pending window blocks input, and no window is ever dropped.
- Simultaneous window accept and pixel accept in one cycle is legal: full throughput of 1 pixel/cycle, with back-to-back windows along a row.
- While `window_valid`=1 and `window_ready`=0, `image_patch` and `window_valid` hold stable.
- `window_valid` falls after acceptance unless the same-cycle pixel produces a new window.
- `frame_done` pulses for exactly one cycle, in the cycle after the final window's acceptance.

## Test plan
- **Single frame, continuous flow:** 8×8 frame, pixel = row·8+col, `window_ready`=1.
  - Exactly 36 windows.
  - First window rises the cycle after pixel 18 is accepted: `[0][0]`=0, `[0][2]`=2, `[2][0]`=16, `[2][2]`=18.
  - Last window: `[0][0]`=45, `[2][2]`=63.
  - One `frame_done` pulse.
- **Row boundary:** the 6th window `[0][0]`=5, `[2][2]`=23. The 7th window `[0][0]`=8, `[2][2]`=26. No window is emitted for col 0/1 pixels of row 3.
- **Backpressure:** hold `window_ready`=0 for 5 cycles at the first window.
  - `pix_ready`=0 throughout, patch stable.
  - After release, all 36 windows are delivered unchanged and in order.
- **Randomized stalls:** random `pix_valid`/`window_ready` gaps. The window sequence is identical to the continuous-flow case.
- **Back-to-back frames:** second frame pixel = 100+row·8+col.
  - No window during the second frame's rows 0–1.
  - Its first window `[0][0]`=100, `[2][2]`=118.
  - Two `frame_done` pulses total.
- **Reset mid-frame:** assert `rst`=0 after 30 pixels.
  - All outputs return to reset values.
  - A subsequent full frame reproduces the continuous-flow results exactly.

Source files
------------

// File: rtl/conv2d_window_generator.sv
// Purpose : streaming FILTER_SIZE x FILTER_SIZE window generator for raster-ordered pixels ("valid" conv, no padding).
// Latency : window_valid rises one cycle after the pixel completing a window is accepted.
// Backpres: pix_ready = !window_valid || window_ready; a pending window stalls input and is never dropped.
//
// Ports:
//   clk, rst          - clock; synchronous active-low reset
//   pix_valid/ready   - pixel input handshake, pix_data in raster order
//   window_valid/ready- window output handshake, image_patch[i][j] (i=0 top row, j=0 left column)
//   frame_done        - one-cycle pulse after the last window of a frame is accepted
module conv2d_window_generator #(
    parameter int FILTER_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 pix_valid,
    output logic                                                 pix_ready,
    input  logic [DATA_WIDTH-1:0]                                pix_data,
    output logic                                                 window_valid,
    input  logic                                                 window_ready,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] image_patch,
    output logic                                                 frame_done
);
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(FILTER_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(FILTER_SIZE - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t                                          state_q, state_d;
    logic [CW-1:0]                                   col_q, col_d;
    logic [RW-1:0]                                   row_q, row_d;
    logic                                            win_vld_q, win_vld_d;
    logic                                            last_win_q, last_win_d;
    logic                                            frame_done_q, frame_done_d;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] patch_q, patch_d;

    // Row memories: line_q[0] holds the oldest buffered row.
    logic [DATA_WIDTH-1:0] line_q [FILTER_SIZE-1][IMG_WIDTH];
    logic [FILTER_SIZE-1:0][DATA_WIDTH-1:0] col_rd;

    logic pix_acc, win_acc, col_wrap, frame_wrap, produce;

    assign pix_ready    = !win_vld_q || window_ready;
    assign pix_acc      = pix_valid && pix_ready;
    assign win_acc      = win_vld_q && window_ready;
    assign col_wrap     = (col_q == COL_LAST);
    assign frame_wrap   = col_wrap && (row_q == ROW_LAST);
    assign window_valid = win_vld_q;
    assign image_patch  = patch_q;
    assign frame_done   = frame_done_q;

    // Column presented to the window: buffered rows on top, live pixel at the bottom.
    always_comb begin
        col_rd = '0;
        for (int k = 0; k < FILTER_SIZE - 1; k++) begin
            col_rd[k] = line_q[k][col_q];
        end
        col_rd[FILTER_SIZE-1] = pix_data;
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_vld_d    = win_vld_q;
        last_win_d   = last_win_q;
        patch_d      = patch_q;
        produce      = 1'b0;
        frame_done_d = win_acc && last_win_q;

        if (pix_acc) begin
            // The window shifts on every accepted pixel, including FILL and
            // column-wrap pixels; those intermediate contents are simply not flagged valid.
            for (int i = 0; i < FILTER_SIZE; i++) begin
                for (int j = 0; j < FILTER_SIZE - 1; j++) begin
                    patch_d[i][j] = patch_q[i][j+1];
                end
                patch_d[i][FILTER_SIZE-1] = col_rd[i];
            end

            col_d = col_wrap ? '0 : col_q + 1'b1;
            if (col_wrap) begin
                row_d = frame_wrap ? '0 : row_q + 1'b1;
            end

            case (state_q)
                FILL: begin
                    if (row_q == ROW_WIN && col_q == '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    produce = (col_q >= COL_WIN);
                    if (frame_wrap) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // A same-cycle accept and produce keeps valid high with the new window.
        if (produce) begin
            win_vld_d  = 1'b1;
            last_win_d = frame_wrap;
        end else if (win_acc) begin
            win_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            win_vld_q    <= 1'b0;
            last_win_q   <= 1'b0;
            frame_done_q <= 1'b0;
            patch_q      <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_vld_q    <= win_vld_d;
            last_win_q   <= last_win_d;
            frame_done_q <= frame_done_d;
            patch_q      <= patch_d;
        end
    end

    // Line buffers carry no reset: stale rows are never exposed by the window gating.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            for (int k = 0; k < FILTER_SIZE - 2; k++) begin
                line_q[k][col_q] <= line_q[k+1][col_q];
            end
            line_q[FILTER_SIZE-2][col_q] <= pix_data;
        end
    end

endmodule

// File: tb/tb_conv2d_window_generator.sv
// Purpose : directed self-checking bench for conv2d_window_generator (3x3 window, 8x8 frame).
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpres: window_ready held low, randomly toggled, or tied high depending on the scenario.
module tb_conv2d_window_generator;
    typedef logic [2:0][2:0][7:0] patch_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       window_valid;
    logic       window_ready;
    patch_t     image_patch;
    logic       frame_done;

    int     errors = 0;
    int     checks = 0;
    int     fd_count = 0;
    bit     done_flag;
    patch_t wins[$];

    always #5 clk = ~clk;

    conv2d_window_generator #(
        .FILTER_SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .window_valid(window_valid),
        .window_ready(window_ready),
        .image_patch (image_patch),
        .frame_done  (frame_done)
    );

    // Record every window that will be accepted on the coming rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (window_valid && window_ready) wins.push_back(image_patch);
            if (frame_done === 1'b1) fd_count++;
        end
    end

    // Reference window k of a frame whose pixel (r,c) = base + r*8 + c.
    function automatic patch_t exp_patch(input int base, input int k);
        patch_t p;
        int r, c;
        r = k / 6;
        c = k % 6;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = 8'(base + (r + i) * 8 + c + j);
        return p;
    endfunction

    function automatic patch_t get_win(input int k);
        if (k < wins.size()) return wins[k];
        return 'x;
    endfunction

    task automatic reset_dut;
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        wins.delete();
        fd_count = 0;
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            pix_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        pix_valid = 1'b1;
        pix_data  = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (pix_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout pixel=%0d pix_ready stuck at %b, required 1", d, pix_ready);
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        window_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL rst_window_valid got=%b exp=0", window_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_pix_ready got=%b exp=1", pix_ready); end
        checks++; if (image_patch !== '0) begin errors++; $display("FAIL rst_patch got=%h exp=0", image_patch); end
        rst = 1'b1;
    endtask

    task automatic test_continuous;
        logic exp_v;
        patch_t g;
        reset_dut();
        window_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(k);
            @(posedge clk); #1;
            exp_v = (k / 8 >= 2) && (k % 8 >= 2);
            checks++;
            if (window_valid !== exp_v) begin
                errors++; $display("FAIL cont_valid_after_pix%0d got=%b exp=%b", k, window_valid, exp_v);
            end
        end
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wins.size() != 36) begin errors++; $display("FAIL cont_count got=%0d exp=36", wins.size()); end
        g = get_win(0);
        checks++; if (g[0][0] !== 8'd0 || g[0][2] !== 8'd2 || g[2][0] !== 8'd16 || g[2][2] !== 8'd18) begin
            errors++; $display("FAIL cont_first got=%h exp 00..02/10..12 corners", g);
        end
        g = get_win(5);
        checks++; if (g[0][0] !== 8'd5 || g[2][2] !== 8'd23) begin errors++; $display("FAIL cont_win6 got=%h exp [0][0]=5 [2][2]=23", g); end
        g = get_win(6);
        checks++; if (g[0][0] !== 8'd8 || g[2][2] !== 8'd26) begin errors++; $display("FAIL cont_win7 got=%h exp [0][0]=8 [2][2]=26", g); end
        g = get_win(35);
        checks++; if (g[0][0] !== 8'd45 || g[2][2] !== 8'd63) begin errors++; $display("FAIL cont_last got=%h exp [0][0]=45 [2][2]=63", g); end
        for (int k = 0; k < 36; k++) begin
            checks++;
            if (get_win(k) !== exp_patch(0, k)) begin
                errors++; $display("FAIL cont_win%0d got=%h exp=%h", k, get_win(k), exp_patch(0, k));
            end
        end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL cont_frame_done got=%0d exp=1", fd_count); end
    endtask

    task automatic test_backpressure;
        reset_dut();
        window_ready = 1'b0;
        for (int k = 0; k < 19; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(k);
            @(posedge clk); #1;
        end
        pix_data = 8'd19;
        repeat (5) begin
            @(negedge clk);
            checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL bp_pix_ready got=%b exp=0", pix_ready); end
            checks++; if (window_valid !== 1'b1) begin errors++; $display("FAIL bp_window_valid got=%b exp=1", window_valid); end
            checks++; if (image_patch !== exp_patch(0, 0)) begin errors++; $display("FAIL bp_patch_stable got=%h exp=%h", image_patch, exp_patch(0, 0)); end
            @(posedge clk); #1;
        end
        window_ready = 1'b1;
        for (int k = 19; k < 64; k++) send_pixel(8'(k), 1'b0);
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wins.size() != 36) begin errors++; $display("FAIL bp_count got=%0d exp=36", wins.size()); end
        for (int k = 0; k < 36; k++) begin
            checks++;
            if (get_win(k) !== exp_patch(0, k)) begin
                errors++; $display("FAIL bp_win%0d got=%h exp=%h", k, get_win(k), exp_patch(0, k));
            end
        end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL bp_frame_done got=%0d exp=1", fd_count); end
    endtask

    task automatic test_random_stalls;
        reset_dut();
        done_flag = 1'b0;
        fork
            begin
                for (int k = 0; k < 64; k++) send_pixel(8'(k), 1'b1);
                pix_valid = 1'b0;
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    window_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                window_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        checks++; if (wins.size() != 36) begin errors++; $display("FAIL rnd_count got=%0d exp=36", wins.size()); end
        for (int k = 0; k < 36; k++) begin
            checks++;
            if (get_win(k) !== exp_patch(0, k)) begin
                errors++; $display("FAIL rnd_win%0d got=%h exp=%h", k, get_win(k), exp_patch(0, k));
            end
        end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL rnd_frame_done got=%0d exp=1", fd_count); end
    endtask

    task automatic test_back_to_back;
        logic exp_v;
        int   p;
        reset_dut();
        window_ready = 1'b1;
        for (int k = 0; k < 128; k++) begin
            p = k % 64;
            pix_valid = 1'b1;
            pix_data  = 8'((k < 64 ? 0 : 100) + p);
            @(posedge clk); #1;
            exp_v = (p / 8 >= 2) && (p % 8 >= 2);
            checks++;
            if (window_valid !== exp_v) begin
                errors++; $display("FAIL b2b_valid_after_pix%0d got=%b exp=%b", k, window_valid, exp_v);
            end
        end
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wins.size() != 72) begin errors++; $display("FAIL b2b_count got=%0d exp=72", wins.size()); end
        checks++; if (get_win(36) !== exp_patch(100, 0) || get_win(36) === 'x) begin
            errors++; $display("FAIL b2b_second_first got=%h exp=%h", get_win(36), exp_patch(100, 0));
        end
        for (int k = 0; k < 72; k++) begin
            checks++;
            if (get_win(k) !== exp_patch(k < 36 ? 0 : 100, k % 36)) begin
                errors++; $display("FAIL b2b_win%0d got=%h exp=%h", k, get_win(k), exp_patch(k < 36 ? 0 : 100, k % 36));
            end
        end
        checks++; if (fd_count != 2) begin errors++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_count); end
    endtask

    task automatic test_reset_midframe;
        reset_dut();
        window_ready = 1'b1;
        for (int k = 0; k < 30; k++) send_pixel(8'(k), 1'b0);
        pix_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_window_valid got=%b exp=0", window_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_frame_done got=%b exp=0", frame_done); end
        checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_pix_ready got=%b exp=1", pix_ready); end
        checks++; if (image_patch !== '0) begin errors++; $display("FAIL mid_rst_patch got=%h exp=0", image_patch); end
        rst = 1'b1;
        wins.delete();
        fd_count = 0;
        for (int k = 0; k < 64; k++) send_pixel(8'(k), 1'b0);
        pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wins.size() != 36) begin errors++; $display("FAIL mid_count got=%0d exp=36", wins.size()); end
        for (int k = 0; k < 36; k++) begin
            checks++;
            if (get_win(k) !== exp_patch(0, k)) begin
                errors++; $display("FAIL mid_win%0d got=%h exp=%h", k, get_win(k), exp_patch(0, k));
            end
        end
        checks++; if (fd_count != 1) begin errors++; $display("FAIL mid_frame_done got=%0d exp=1", fd_count); end
    endtask

    initial begin
        rst = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        window_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_continuous();
        test_backpressure();
        test_random_stalls();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
